// File: rtl/bcd_value_assembler.sv
// Two-digit BCD entry (tens, then units) assembled into a range-checked
// binary value, with clear and optional inter-digit timeout.
module bcd_value_assembler #(
  parameter int MAX_VALUE      = 59,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       clear,
  output logic [5:0] value,
  output logic       value_valid,
  output logic       error,
  output logic       awaiting_units,
  output logic [2:0] tens_held
);

  localparam int TW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TLIM =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] TLIM_V   = TW'(TLIM);
  localparam logic [3:0]    MAX_TENS = 4'(MAX_VALUE / 10);
  localparam logic [6:0]    MAX_SUM  = 7'(MAX_VALUE);

  typedef enum logic {IDLE, WAIT_UNITS} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [2:0]    tens_nx;
  logic [5:0]    value_nx;
  logic          vv_nx, err_nx;
  logic [6:0]    sum;

  // tens*10 as (tens<<3)+(tens<<1), kept 7 bits wide for the range check
  assign sum = {1'b0, tens_held, 3'b000}
             + {3'b000, tens_held, 1'b0}
             + {3'b000, digit};

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    tens_nx  = tens_held;
    value_nx = value;
    vv_nx    = 1'b0;
    err_nx   = 1'b0;
    if (clear) begin
      state_nx = IDLE;
      timer_nx = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (digit_valid) begin
            if (digit > 4'd9 || digit > MAX_TENS) begin
              err_nx = 1'b1;
            end else begin
              tens_nx  = digit[2:0];
              timer_nx = '0;
              state_nx = WAIT_UNITS;
            end
          end
        end
        WAIT_UNITS: begin
          if (digit_valid) begin
            state_nx = IDLE;
            timer_nx = '0;
            if (digit > 4'd9 || sum > MAX_SUM) begin
              err_nx = 1'b1;
            end else begin
              value_nx = sum[5:0];
              vv_nx    = 1'b1;
            end
          end else if (TIMEOUT_CYCLES > 0) begin
            // a digit in the final allowed cycle wins over the timeout
            if (timer == TLIM_V) begin
              err_nx   = 1'b1;
              state_nx = IDLE;
              timer_nx = '0;
            end else if (timer != '1) begin
              timer_nx = timer + 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      tens_held   <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      tens_held   <= tens_nx;
      value       <= value_nx;
      value_valid <= vv_nx;
      error       <= err_nx;
    end
  end

  assign awaiting_units = (state == WAIT_UNITS);

endmodule

// File: tb/tb_bcd_value_assembler.sv
// Directed bench for bcd_value_assembler: three instances
// (max 59, max 23, max 59 with timeout 5) driven independently.
module tb_bcd_value_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[3];
  logic       dv[3];
  logic [3:0] dg[3];
  logic       clr[3];
  logic [5:0] val[3];
  logic       vv[3];
  logic       er[3];
  logic       aw[3];
  logic [2:0] th[3];

  bcd_value_assembler #(.MAX_VALUE(59), .TIMEOUT_CYCLES(0)) u59 (
    .clk(clk), .rst(rst[0]), .digit_valid(dv[0]), .digit(dg[0]),
    .clear(clr[0]), .value(val[0]), .value_valid(vv[0]),
    .error(er[0]), .awaiting_units(aw[0]), .tens_held(th[0]));

  bcd_value_assembler #(.MAX_VALUE(23), .TIMEOUT_CYCLES(0)) u23 (
    .clk(clk), .rst(rst[1]), .digit_valid(dv[1]), .digit(dg[1]),
    .clear(clr[1]), .value(val[1]), .value_valid(vv[1]),
    .error(er[1]), .awaiting_units(aw[1]), .tens_held(th[1]));

  bcd_value_assembler #(.MAX_VALUE(59), .TIMEOUT_CYCLES(5)) uto (
    .clk(clk), .rst(rst[2]), .digit_valid(dv[2]), .digit(dg[2]),
    .clear(clr[2]), .value(val[2]), .value_valid(vv[2]),
    .error(er[2]), .awaiting_units(aw[2]), .tens_held(th[2]));

  typedef struct {
    int         u;
    bit         r;
    bit         v;
    logic [3:0] d;
    bit         c;
    logic [5:0] ev;
    bit         evv;
    bit         eer;
    bit         eaw;
    logic [2:0] et;
  } vec_t;

  vec_t tbl[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0;
      dv[i]  = 1'b0;
      dg[i]  = 4'd0;
      clr[i] = 1'b0;
    end
  endtask

  task automatic step(int u, bit r, bit v, logic [3:0] d, bit c);
    idle_all();
    rst[u] = r;
    dv[u]  = v;
    dg[u]  = d;
    clr[u] = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(int u, string tag, logic [5:0] ev,
                            bit evv, bit eer, bit eaw, logic [2:0] et);
    chk($sformatf("%s.u%0d.value", tag, u), 8'(val[u]), 8'(ev));
    chk($sformatf("%s.u%0d.value_valid", tag, u), 8'(vv[u]), 8'(evv));
    chk($sformatf("%s.u%0d.error", tag, u), 8'(er[u]), 8'(eer));
    chk($sformatf("%s.u%0d.awaiting", tag, u), 8'(aw[u]), 8'(eaw));
    chk($sformatf("%s.u%0d.tens_held", tag, u), 8'(th[u]), 8'(et));
  endtask

  function automatic vec_t mk(int u, bit r, bit v, logic [3:0] d, bit c,
                              logic [5:0] ev, bit evv, bit eer,
                              bit eaw, logic [2:0] et);
    vec_t x;
    x = '{u:u, r:r, v:v, d:d, c:c, ev:ev, evv:evv,
          eer:eer, eaw:eaw, et:et};
    return x;
  endfunction

  initial begin
    // max 59, no timeout
    tbl.push_back(mk(0, 0, 1, 4'd4,  0, 6'd0,  0, 0, 1, 3'd4));
    tbl.push_back(mk(0, 0, 1, 4'd7,  0, 6'd47, 1, 0, 0, 3'd4));
    tbl.push_back(mk(0, 0, 0, 4'd0,  0, 6'd47, 0, 0, 0, 3'd4));
    tbl.push_back(mk(0, 0, 1, 4'd6,  0, 6'd47, 0, 1, 0, 3'd4));
    tbl.push_back(mk(0, 0, 1, 4'd5,  0, 6'd47, 0, 0, 1, 3'd5));
    tbl.push_back(mk(0, 0, 1, 4'd9,  0, 6'd59, 1, 0, 0, 3'd5));
    tbl.push_back(mk(0, 0, 1, 4'd0,  0, 6'd59, 0, 0, 1, 3'd0));
    tbl.push_back(mk(0, 0, 1, 4'd0,  0, 6'd0,  1, 0, 0, 3'd0));
    tbl.push_back(mk(0, 0, 1, 4'd12, 0, 6'd0,  0, 1, 0, 3'd0));
    tbl.push_back(mk(0, 0, 1, 4'd3,  0, 6'd0,  0, 0, 1, 3'd3));
    tbl.push_back(mk(0, 0, 1, 4'd15, 0, 6'd0,  0, 1, 0, 3'd3));
    tbl.push_back(mk(0, 0, 1, 4'd2,  0, 6'd0,  0, 0, 1, 3'd2));
    tbl.push_back(mk(0, 0, 1, 4'd8,  1, 6'd0,  0, 0, 0, 3'd2));
    tbl.push_back(mk(0, 0, 1, 4'd8,  0, 6'd0,  0, 1, 0, 3'd2));
    tbl.push_back(mk(0, 0, 1, 4'd1,  0, 6'd0,  0, 0, 1, 3'd1));
    tbl.push_back(mk(0, 0, 1, 4'd2,  0, 6'd12, 1, 0, 0, 3'd1));
    tbl.push_back(mk(0, 0, 1, 4'd4,  0, 6'd12, 0, 0, 1, 3'd4));
    tbl.push_back(mk(0, 1, 0, 4'd0,  0, 6'd0,  0, 0, 0, 3'd0));
    tbl.push_back(mk(0, 0, 1, 4'd1,  0, 6'd0,  0, 0, 1, 3'd1));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(0, 0, 0, 4'd0, 0, 6'd0, 0, 0, 1, 3'd1));
    tbl.push_back(mk(0, 0, 1, 4'd0,  0, 6'd10, 1, 0, 0, 3'd1));
    // max 23
    tbl.push_back(mk(1, 0, 1, 4'd1,  0, 6'd0,  0, 0, 1, 3'd1));
    tbl.push_back(mk(1, 0, 1, 4'd5,  0, 6'd15, 1, 0, 0, 3'd1));
    tbl.push_back(mk(1, 0, 1, 4'd3,  0, 6'd15, 0, 1, 0, 3'd1));
    tbl.push_back(mk(1, 0, 1, 4'd2,  0, 6'd15, 0, 0, 1, 3'd2));
    tbl.push_back(mk(1, 0, 1, 4'd4,  0, 6'd15, 0, 1, 0, 3'd2));
    tbl.push_back(mk(1, 0, 1, 4'd2,  0, 6'd15, 0, 0, 1, 3'd2));
    tbl.push_back(mk(1, 0, 1, 4'd3,  0, 6'd23, 1, 0, 0, 3'd2));

    idle_all();
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      expect_out(i, "reset", 6'd0, 0, 0, 0, 3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].u, tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].c);
      expect_out(tbl[i].u, $sformatf("vec%0d", i), tbl[i].ev,
                 tbl[i].evv, tbl[i].eer, tbl[i].eaw, tbl[i].et);
    end

    // timeout: tens 3 in cycle 0, nothing else -> error in cycle 6
    step(2, 0, 1, 4'd3, 0);
    expect_out(2, "to_c1", 6'd0, 0, 0, 1, 3'd3);
    for (int k = 1; k <= 5; k++) begin
      step(2, 0, 0, 4'd0, 0);
      expect_out(2, $sformatf("to_c%0d", k + 1), 6'd0, 0,
                 (k == 5), (k < 5), 3'd3);
    end
    step(2, 0, 0, 4'd0, 0);
    expect_out(2, "to_after", 6'd0, 0, 0, 0, 3'd3);

    // units digit in cycle 5 still beats the timeout
    step(2, 0, 1, 4'd3, 0);
    for (int k = 1; k <= 4; k++) begin
      step(2, 0, 0, 4'd0, 0);
      expect_out(2, $sformatf("late_c%0d", k + 1), 6'd0, 0, 0, 1, 3'd3);
    end
    step(2, 0, 1, 4'd1, 0);
    expect_out(2, "late_units", 6'd31, 1, 0, 0, 3'd3);
    step(2, 0, 0, 4'd0, 0);
    expect_out(2, "late_after", 6'd31, 0, 0, 0, 3'd3);

    idle_all();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
